if_fetch_bridge: RTL and testbench
==================================

IF_FETCH_BRIDGE -- requirements
Module: if_fetch_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of core and memory ports.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rom_ce_i  input  1  core fetch enable (driven by the pc register's chip-enable).
REQ-006 SHALL have port rom_addr_i  input  ADDR_W  core fetch byte address.
REQ-007 SHALL have port rom_data_o  output  DATA_W  instruction word to the core's IF/ID register.
REQ-008 SHALL have port stallreq_o  output  1  fetch-not-ready; core holds pc and IF/ID while high.
REQ-009 SHALL have ports mem_req_o output 1, mem_addr_o output ADDR_W, mem_gnt_i input 1, for the memory request handshake.
REQ-010 SHALL have ports mem_rvalid_i input 1, mem_rdata_i input DATA_W, for the memory read response.

Function
REQ-011 SHALL hold a 2-entry word buffer; each entry = valid, word tag addr[ADDR_W-1:2], data; addr[1:0] ignored everywhere.
REQ-012 SHALL, when rom_ce_i=0, drive rom_data_o=0 and stallreq_o=0 and start no demand fetch.
REQ-013 SHALL, when rom_ce_i=1 and a valid entry's tag matches, drive that entry's data on rom_data_o combinationally with stallreq_o=0 (hit, zero latency).
REQ-014 SHALL, when rom_ce_i=1 and no entry hits, drive stallreq_o=1 and rom_data_o=0 until a hit occurs.
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT; reset state IDLE.
REQ-016 SHALL leave IDLE for REQ on a demand miss, latching the word address as the pending address.
REQ-017 SHALL in REQ drive mem_req_o=1 and mem_addr_o={pending tag,2'b00} stable until mem_gnt_i=1, then go to WAIT next cycle.
REQ-018 SHALL in WAIT keep mem_req_o=0; on mem_rvalid_i=1 write mem_rdata_i and pending tag into the entry chosen by a 1-bit round-robin pointer, set valid, toggle pointer, go to IDLE.
REQ-019 SHALL ignore mem_rvalid_i in IDLE and REQ.
REQ-020 SHALL keep only one memory transaction outstanding; a rom_addr_i change during REQ/WAIT does not cancel it; after fill, the new address is re-checked and misses again if different.
REQ-021 SHALL give minimum miss latency of 3 cycles (miss cycle, REQ with gnt=1, WAIT with rvalid=1); first hit in the following cycle.
REQ-022 SHALL drive mem_addr_o=0 whenever mem_req_o=0.

Reset
REQ-023 SHALL on rst=0 at a clock edge: FSM to IDLE, both entries invalid, pointer to 0, pending address 0, from any state including REQ/WAIT.
REQ-024 SHALL drive during reset: rom_data_o=0, stallreq_o=0, mem_req_o=0, mem_addr_o=0.
REQ-025 SHALL discard a response arriving after reset released mid-transaction (per REQ-019).

Configuration
REQ-026 SHALL, with macro IF_PREFETCH_EN defined, add states PREQ and PWAIT: in IDLE with no demand miss and the word after the last hit/fill address (addr+4, wrapping 0xFFFFFFFC->0x00000000) not valid in the buffer, issue a prefetch via the same handshake and fill per REQ-018.
REQ-027 SHALL, with IF_PREFETCH_EN, let a demand miss arising during PREQ/PWAIT keep stallreq_o=1, complete the prefetch, then serve the demand from IDLE; never abort a prefetch.
REQ-028 SHALL, without IF_PREFETCH_EN, contain no prefetch logic and issue memory requests only on demand misses.

Verification
REQ-029 SHALL cover: reset, rom_ce_i=1, addr 0x00000000, gnt same cycle, rvalid 1 cycle later data 0x34011100 -> stallreq_o high 3 cycles, then rom_data_o=0x34011100, stallreq_o=0.
REQ-030 SHALL cover: addr 0x00000000 then 0x00000004 then 0x00000000 -> second return to 0x0 hits with no mem_req_o (both entries valid).
REQ-031 SHALL cover: mem_gnt_i held 0 for 5 cycles -> mem_req_o and mem_addr_o=0x00000008 stable 5 cycles, stallreq_o=1 throughout.
REQ-032 SHALL cover: rst=0 during WAIT, late rvalid data 0xDEADBEEF after release -> buffer stays invalid, next fetch of same addr misses.
REQ-033 SHALL cover: rom_ce_i=0 -> rom_data_o=0x00000000, stallreq_o=0, mem_req_o=0.
REQ-034 SHALL cover, with IF_PREFETCH_EN: hit at 0xFFFFFFFC -> prefetch mem_addr_o=0x00000000; later fetch of 0x00000000 hits with zero stall.

Source files
------------

// File: rtl/if_fetch_bridge.sv
// Instruction-fetch bridge: a 2-entry word buffer in front of a req/gnt + rvalid memory port.
// Optional next-word prefetch is enabled by defining IF_PREFETCH_EN.
module if_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int TAG_W = ADDR_W - 2;

`ifdef IF_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PREQ, PWAIT} state_e;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
`endif

  state_e           state_q, state_d;
  logic [1:0]       vld_q, vld_d;
  logic             ptr_q, ptr_d;
  logic [TAG_W-1:0] pend_q, pend_d;
  logic [TAG_W-1:0] tag_q  [2];
  logic [DATA_W-1:0] data_q [2];

  logic [TAG_W-1:0] req_tag;
  logic             hit0, hit1, hit, miss, fill_en;
  logic             unused_lsb;

  assign req_tag    = rom_addr_i[ADDR_W-1:2];
  assign unused_lsb = ^rom_addr_i[1:0];

  assign hit0 = vld_q[0] && (tag_q[0] == req_tag);
  assign hit1 = vld_q[1] && (tag_q[1] == req_tag);
  assign hit  = rom_ce_i && (hit0 || hit1);
  assign miss = rom_ce_i && !hit;

  // Every output is forced low while rst is asserted, independent of held state.
  assign rom_data_o = (rst && hit) ? (hit0 ? data_q[0] : data_q[1]) : '0;
  assign stallreq_o = rst && miss;
`ifdef IF_PREFETCH_EN
  assign mem_req_o  = rst && ((state_q == REQ) || (state_q == PREQ));
`else
  assign mem_req_o  = rst && (state_q == REQ);
`endif
  assign mem_addr_o = mem_req_o ? {pend_q, 2'b00} : '0;

`ifdef IF_PREFETCH_EN
  // Prefetch follows the last demand hit/fill only; prefetch fills do not advance it,
  // so the 2-entry buffer is never run ahead of the core and thrashed.
  logic [TAG_W-1:0] last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic [TAG_W-1:0] pf_tag;
  logic             pf_needed;

  assign pf_tag    = last_q + 1'b1;
  assign pf_needed = last_vld_q
                  && !(vld_q[0] && (tag_q[0] == pf_tag))
                  && !(vld_q[1] && (tag_q[1] == pf_tag));
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    fill_en = 1'b0;
`ifdef IF_PREFETCH_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (hit) begin
      last_d     = req_tag;
      last_vld_d = 1'b1;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          pend_d  = req_tag;
          state_d = REQ;
        end
`ifdef IF_PREFETCH_EN
        else if (pf_needed) begin
          pend_d  = pf_tag;
          state_d = PREQ;
        end
`endif
      end
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid_i) begin
          fill_en = 1'b1;
          state_d = IDLE;
`ifdef IF_PREFETCH_EN
          last_d     = pend_q;
          last_vld_d = 1'b1;
`endif
        end
      end
`ifdef IF_PREFETCH_EN
      PREQ:  if (mem_gnt_i) state_d = PWAIT;
      PWAIT: begin
        if (mem_rvalid_i) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (fill_en) begin
      vld_d[ptr_q] = 1'b1;
      ptr_d        = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      ptr_q   <= 1'b0;
      pend_q  <= '0;
`ifdef IF_PREFETCH_EN
      last_q     <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
`ifdef IF_PREFETCH_EN
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
`endif
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[ptr_q]  <= pend_q;
      data_q[ptr_q] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_bridge.sv
// Directed, table-driven bench for if_fetch_bridge: one vector per clock cycle,
// inputs driven on the falling edge and outputs compared just after.
module tb_if_fetch_bridge;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst_n;
    logic        ce;
    logic [31:0] addr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_stall;
    logic        exp_req;
    logic [31:0] exp_maddr;
  } vec_t;

  if_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .stallreq_o   (stallreq_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, compare the combinational outputs 1ns later.
  task automatic run(input vec_t v, input string name);
    @(negedge clk);
    rst          = v.rst_n;
    rom_ce_i     = v.ce;
    rom_addr_i   = v.addr;
    mem_gnt_i    = v.gnt;
    mem_rvalid_i = v.rv;
    mem_rdata_i  = v.rdata;
    #1;
    check({name, ".rom_data"}, rom_data_o, v.exp_data);
    check({name, ".stall"},    {31'd0, stallreq_o}, {31'd0, v.exp_stall});
    check({name, ".mem_req"},  {31'd0, mem_req_o},  {31'd0, v.exp_req});
    check({name, ".mem_addr"}, mem_addr_o, v.exp_maddr);
  endtask

  vec_t vecs [14];

  initial begin
    rst = 1'b0; rom_ce_i = 1'b0; rom_addr_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

`ifndef IF_PREFETCH_EN
    //          rst ce addr  gnt rv rdata          exp_data       st req maddr
    vecs[0]  = '{0, 1, 'h0,  0,  0, 'h0,           'h0,           0, 0,  'h0};
    vecs[1]  = '{0, 1, 'h0,  1,  1, 'h0,           'h0,           0, 0,  'h0};
    vecs[2]  = '{1, 1, 'h0,  1,  0, 'h0,           'h0,           1, 0,  'h0};
    vecs[3]  = '{1, 1, 'h0,  1,  0, 'h0,           'h0,           1, 1,  'h0};
    vecs[4]  = '{1, 1, 'h0,  0,  1, 'h34011100,    'h0,           1, 0,  'h0};
    vecs[5]  = '{1, 1, 'h0,  0,  0, 'h0,           'h34011100,    0, 0,  'h0};
    vecs[6]  = '{1, 1, 'h4,  0,  0, 'h0,           'h0,           1, 0,  'h0};
    vecs[7]  = '{1, 1, 'h4,  1,  0, 'h0,           'h0,           1, 1,  'h4};
    vecs[8]  = '{1, 1, 'h4,  0,  1, 'hAAAA0004,    'h0,           1, 0,  'h0};
    vecs[9]  = '{1, 1, 'h4,  0,  0, 'h0,           'hAAAA0004,    0, 0,  'h0};
    vecs[10] = '{1, 1, 'h0,  0,  0, 'h0,           'h34011100,    0, 0,  'h0};
    vecs[11] = '{1, 1, 'h2,  0,  0, 'h0,           'h34011100,    0, 0,  'h0};
    vecs[12] = '{1, 0, 'h8,  0,  0, 'h0,           'h0,           0, 0,  'h0};
    vecs[13] = '{1, 0, 'h8,  0,  1, 'h55,          'h0,           0, 0,  'h0};

    for (int i = 0; i < 14; i++) run(vecs[i], $sformatf("v%0d", i));

    // Grant withheld 5 cycles, then address change while the response is pending.
    run('{1, 1, 'h8, 0, 0, 'h0, 'h0, 1, 0, 'h0}, "hold_miss");
    for (int k = 0; k < 5; k++)
      run('{1, 1, 'h8, 0, 0, 'h0, 'h0, 1, 1, 'h8}, $sformatf("hold%0d", k));
    run('{1, 1, 'h8, 1, 0, 'h0,        'h0,        1, 1, 'h8}, "hold_gnt");
    run('{1, 1, 'hC, 0, 0, 'h0,        'h0,        1, 0, 'h0}, "wait_chg");
    run('{1, 1, 'hC, 0, 1, 'h08080808, 'h0,        1, 0, 'h0}, "wait_fill8");
    run('{1, 1, 'hC, 1, 0, 'h0,        'h0,        1, 0, 'h0}, "recheck_miss");
    run('{1, 1, 'hC, 1, 0, 'h0,        'h0,        1, 1, 'hC}, "recheck_req");
    run('{1, 1, 'hC, 0, 1, 'h0C0C0C0C, 'h0,        1, 0, 'h0}, "recheck_fill");
    run('{1, 1, 'hC, 0, 0, 'h0,        'h0C0C0C0C, 0, 0, 'h0}, "hit_c");
    run('{1, 1, 'h8, 0, 0, 'h0,        'h08080808, 0, 0, 'h0}, "hit_8");
    run('{1, 1, 'h0, 0, 0, 'h0,        'h0,        1, 0, 'h0}, "evicted_0");

    // Reset from REQ and from WAIT; a late response must not fill the buffer.
    run('{0, 1, 'h10, 0, 0, 'h0,        'h0,      0, 0, 'h0},  "rst_in_req");
    run('{1, 1, 'h10, 0, 0, 'h0,        'h0,      1, 0, 'h0},  "b_miss");
    run('{1, 1, 'h10, 1, 0, 'h0,        'h0,      1, 1, 'h10}, "b_req");
    run('{0, 1, 'h10, 0, 0, 'h0,        'h0,      0, 0, 'h0},  "rst_in_wait");
    run('{1, 1, 'h10, 0, 1, 'hDEADBEEF, 'h0,      1, 0, 'h0},  "late_rvalid");
    run('{1, 1, 'h10, 0, 1, 'hDEADBEEF, 'h0,      1, 1, 'h10}, "rv_in_req");
    run('{1, 1, 'h10, 1, 0, 'h0,        'h0,      1, 1, 'h10}, "c_gnt");
    run('{1, 1, 'h10, 0, 1, 'h1010,     'h0,      1, 0, 'h0},  "c_fill");
    run('{1, 1, 'h10, 0, 0, 'h0,        'h1010,   0, 0, 'h0},  "c_hit");
    run('{1, 1, 'h0,  0, 0, 'h0,        'h0,      1, 0, 'h0},  "c_old_gone");
`else
    // Wrap-around prefetch: a hit at 0xFFFFFFFC prefetches 0x00000000.
    run('{0, 1, 'hFFFFFFFC, 0, 0, 'h0,  'h0,  0, 0, 'h0}, "p_rst");
    run('{1, 1, 'hFFFFFFFC, 0, 0, 'h0,  'h0,  1, 0, 'h0}, "p_miss");
    run('{1, 1, 'hFFFFFFFC, 1, 0, 'h0,  'h0,  1, 1, 'hFFFFFFFC}, "p_req");
    run('{1, 1, 'hFFFFFFFC, 0, 1, 'h11, 'h0,  1, 0, 'h0}, "p_fill");
    run('{1, 1, 'hFFFFFFFC, 0, 0, 'h0,  'h11, 0, 0, 'h0}, "p_hit");
    run('{1, 1, 'hFFFFFFFC, 1, 0, 'h0,  'h11, 0, 1, 'h0}, "p_preq");
    run('{1, 1, 'hFFFFFFFC, 0, 1, 'h22, 'h11, 0, 0, 'h0}, "p_pfill");
    run('{1, 1, 'h0,        0, 0, 'h0,  'h22, 0, 0, 'h0}, "p_hit0");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
